// File: rtl/nr_divider_param.sv
// Multi-cycle non-restoring divider, one quotient bit per cycle, with optional
// two's-complement operands handled as magnitudes plus recorded result signs.
module nr_divider_param #(
  parameter int P_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [P_WIDTH-1:0] dividend_in,
  input  logic [P_WIDTH-1:0] divisor_in,
  output logic               busy,
  output logic [P_WIDTH-1:0] quotient_out,
  output logic [P_WIDTH-1:0] remainder_out,
  output logic               done,
  output logic               div_by_zero
);
  localparam int CW = $clog2(P_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [P_WIDTH:0]   prem, shifted, prem_nx;
  logic [P_WIDTH-1:0] quo, dvs, a_mag, b_mag, rem_mag;
  logic               a_neg, b_neg, q_neg, r_neg, dz;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (divisor_in == '0) ? DONE : CALC;
      CALC: if (cnt == CW'(P_WIDTH - 1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    a_neg   = signed_mode & dividend_in[P_WIDTH-1];
    b_neg   = signed_mode & divisor_in[P_WIDTH-1];
    a_mag   = a_neg ? -dividend_in : dividend_in;
    b_mag   = b_neg ? -divisor_in  : divisor_in;
    // quo doubles as the dividend shift register; its MSB feeds the remainder
    shifted = {prem[P_WIDTH-1:0], quo[P_WIDTH-1]};
    prem_nx = prem[P_WIDTH] ? shifted + {1'b0, dvs} : shifted - {1'b0, dvs};
    rem_mag = prem[P_WIDTH] ? prem[P_WIDTH-1:0] + dvs : prem[P_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      prem          <= '0;
      quo           <= '0;
      dvs           <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      dz            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      div_by_zero   <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          quo   <= a_mag;
          dvs   <= b_mag;
          prem  <= '0;
          cnt   <= '0;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          dz    <= (divisor_in == '0);
          busy  <= 1'b1;
        end
        CALC: begin
          prem <= prem_nx;
          quo  <= {quo[P_WIDTH-2:0], ~prem_nx[P_WIDTH]};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          quotient_out  <= q_neg ? -quo : quo;
          remainder_out <= r_neg ? -rem_mag : rem_mag;
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= dz;
          cnt         <= '0;
          // divide-by-zero skips CALC, so quo still holds |dividend|
          if (dz) begin
            quotient_out  <= '1;
            remainder_out <= r_neg ? -quo : quo;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nr_divider_param.sv
// Bench for nr_divider_param at widths 8 and 32: random and directed divisions
// against an arithmetic reference, latency, reset and start-while-busy checks.
module tb_nr_divider_param;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 0, sm8 = 0, busy8, done8, dz8;
  logic [7:0]  a8 = 0, b8 = 0, q8, r8;
  logic        start32 = 0, sm32 = 0, busy32, done32, dz32;
  logic [31:0] a32 = 0, b32 = 0, q32, r32;

  int errors = 0, checks = 0;

  nr_divider_param #(.P_WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .dividend_in(a8), .divisor_in(b8), .busy(busy8), .quotient_out(q8),
    .remainder_out(r8), .done(done8), .div_by_zero(dz8));

  nr_divider_param #(.P_WIDTH(32)) u_div32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32),
    .dividend_in(a32), .divisor_in(b32), .busy(busy32), .quotient_out(q32),
    .remainder_out(r32), .done(done32), .div_by_zero(dz32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain / and % on sign-extended 64-bit values (truncates toward zero)
  task automatic model(input int w, input bit sm, input logic [31:0] a_i, input logic [31:0] b_i,
                       output logic [31:0] q, output logic [31:0] r);
    logic [31:0] mask, a, b;
    longint sa, sb;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    a = a_i & mask;
    b = b_i & mask;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (!sm) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      q = 32'(sa / sb) & mask;
      r = 32'(sa % sb) & mask;
    end
  endtask

  function automatic logic dn(input int w);
    return (w == 8) ? done8 : done32;
  endfunction

  task automatic drive(input int w, input bit st, input bit sm, input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin start8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
    else        begin start32 = st; sm32 = sm; a32 = a; b32 = b; end
  endtask

  // One division: checks busy, done latency, results, and the done pulse width
  task automatic op(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b,
                    input bit repulse = 0);
    logic [31:0] eq, er, mask;
    int lat, n;
    bit seen;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    model(w, sm, a, b, eq, er);
    lat = ((b & mask) == 0) ? 1 : w + 2;
    @(negedge clk);
    drive(w, 1'b1, sm, a, b);
    @(posedge clk);
    #1;
    drive(w, 1'b0, $urandom_range(0, 1), $urandom, $urandom);
    chk("busy_after_start", (w == 8) ? busy8 : busy32, 1'b1);
    seen = 0;
    n = 0;
    for (int i = 1; i <= 80 && !seen; i++) begin
      if (repulse && i == 3) drive(w, 1'b1, ~sm, $urandom, $urandom_range(1, 5));
      if (repulse && i == 4) drive(w, 1'b0, sm, $urandom, $urandom);
      @(posedge clk);
      #1;
      if (dn(w)) begin seen = 1; n = i; end
    end
    chk("done_seen", seen, 1'b1);
    chk("latency", n, lat);
    if (w == 8) begin
      chk("quotient8", q8, eq[7:0]);
      chk("remainder8", r8, er[7:0]);
      chk("dz8", dz8, (b[7:0] == 0));
      chk("busy_at_done8", busy8, 1'b0);
    end else begin
      chk("quotient32", q32, eq);
      chk("remainder32", r32, er);
      chk("dz32", dz32, (b == 0));
      chk("busy_at_done32", busy32, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("done_pulse_width", dn(w), 1'b0);
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("idle_outputs8", {busy8, done8, dz8, q8, r8}, '0);
      chk("idle_outputs32", {busy32, done32, dz32, q32, r32}, '0);
    end

    // width-8 boundaries, then random unsigned and signed
    op(8, 0, 0, 1);   op(8, 0, 255, 1); op(8, 0, 255, 255);
    op(8, 0, 0, 255); op(8, 0, 1, 255); op(8, 0, 200, 0);
    op(8, 1, 8'h80, 8'hFF); op(8, 1, 8'h80, 0); op(8, 1, 8'h81, 8'h7F);
    for (int i = 0; i < 300; i++) op(8, 0, $urandom_range(0, 255), $urandom_range(1, 255));
    for (int i = 0; i < 100; i++) op(8, 1, $urandom_range(0, 255), $urandom_range(0, 255));

    // width-32 directed signed and divide-by-zero cases
    op(32, 1, -32'sd7, 32'd2);
    op(32, 1, 32'd7, -32'sd2);
    op(32, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    op(32, 0, 32'h1F, 0);
    op(32, 0, 32'd9, 32'd3);
    op(32, 1, 32'h1F, 0);
    op(32, 1, 32'd9, 32'd3);
    op(32, 1, -32'sd100, 0);
    op(32, 0, 32'd1000, 32'd7, 1'b1);
    op(32, 1, -32'sd1000, 32'd7, 1'b1);
    for (int i = 0; i < 120; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom;
      op(32, $urandom_range(0, 1), a, b);
    end

    // reset pulse at iteration 5 aborts the operation, start held during reset
    @(negedge clk);
    drive(8, 1'b1, 0, 8'd200, 8'd3);
    @(posedge clk);
    #1 drive(8, 1'b0, 0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(8, 1'b1, 0, 8'd50, 8'd5);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8, 1'b0, 0, 0, 0);
    begin
      bit any_done = 0;
      repeat (15) begin
        @(posedge clk);
        #1;
        if (done8) any_done = 1;
        chk("abort_outputs8", {busy8, dz8, q8, r8}, '0);
      end
      chk("abort_no_done", any_done, 1'b0);
    end
    op(8, 0, 8'd200, 8'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
